flash_page_reader: RTL and testbench
====================================

FLASH_PAGE_READER -- requirements
Module: flash_page_reader

Interface
REQ-001 Parameter CLK_DIV, default 2: SPI half-period in i_clk cycles (legal range 1..255).
REQ-002 Parameter STARTUP_CYCLES, default 2700: cycles after reset before the first transaction may start.
REQ-003 i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  one-cycle request to load a 64-byte page.
REQ-006 i_address  input  24  flash byte address of the page, sampled when a start is accepted.
REQ-007 o_busy  output  1  high from accepted start until o_done.
REQ-008 o_done  output  1  one-cycle pulse when a page load completes.
REQ-009 i_flashMISO  input  1  flash serial data out.
REQ-010 o_flashCLK, o_flashMOSI, o_flashCS  output  1 each  SPI mode-0 clock, data and chip-select (active-low).
REQ-011 i_charAddress  input  6  text-buffer read index, from the text renderer.
REQ-012 o_character  output  8  text-buffer byte at i_charAddress.

Function
REQ-013 States SHALL be STARTUP, IDLE, CMD, DATA, FINISH; reset enters STARTUP.
REQ-014 STARTUP SHALL count STARTUP_CYCLES cycles, then go to IDLE; i_start is ignored in STARTUP.
REQ-015 In IDLE, i_start=1 SHALL latch i_address, assert o_busy, drive o_flashCS low and enter CMD on the next cycle.
REQ-016 i_start while o_busy=1 SHALL be ignored, with no effect on the transaction in progress.
REQ-017 CMD SHALL shift 32 bits MSB-first: 0x03, then address[23:0].
REQ-018 SPI timing: o_flashCLK idles low; each bit is o_flashCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-019 o_flashMOSI SHALL change only while o_flashCLK is low; i_flashMISO SHALL be sampled on the cycle o_flashCLK rises.
REQ-020 DATA SHALL clock 512 bits (64 bytes, MSB-first), with o_flashMOSI held at 0.
REQ-021 Byte n (n = 0..63) SHALL be written to buffer entry n on the cycle its 8th bit is sampled.
REQ-022 FINISH SHALL drive o_flashCS high and o_flashCLK low, pulse o_done for one cycle and clear o_busy in that same cycle.
REQ-023 FINISH SHALL hold for 2*CLK_DIV cycles before IDLE, guaranteeing minimum chip-select-high time.
REQ-024 A full transaction SHALL take 1 + 544*2*CLK_DIV + 2*CLK_DIV cycles from the start cycle to IDLE.
REQ-025 o_character SHALL be registered: it reflects i_charAddress of the previous cycle (1-cycle latency).
REQ-026 The read port SHALL stay live during loads; entries not yet rewritten SHALL return their old value.
REQ-027 If a read and a write hit the same entry in one cycle, the read SHALL return the old byte.
REQ-028 The 24-bit address SHALL be passed to the flash unmodified; the flash wraps any page that crosses 0xFFFFFF.

Reset
REQ-029 i_rst=1 SHALL, on the next edge, set o_flashCS=1, o_flashCLK=0, o_flashMOSI=0, o_busy=0, o_done=0, o_character=0x20 and all counters to 0.
REQ-030 Reset SHALL fill all 64 buffer entries with 0x20 (space).
REQ-031 Reset mid-transaction SHALL abort it, with no o_done pulse, then re-run STARTUP.

Configuration
REQ-032 Macro FLASH_PAGE_READER_PRINTABLE_EN, when defined, SHALL store each received byte outside 0x20..0x7E as 0x20.
REQ-033 Without FLASH_PAGE_READER_PRINTABLE_EN, received bytes SHALL be stored unmodified.

Verification
REQ-034 Startup guard: CLK_DIV=1, STARTUP_CYCLES=10, i_start at cycle 5 after reset -> no o_flashCS activity; i_start at cycle 12 -> accepted.
REQ-035 Command format: i_address=0x012345 -> MOSI bits 0x03,0x01,0x23,0x45; o_flashCLK period 2*CLK_DIV; o_done exactly 1 + 1088*CLK_DIV cycles after the start cycle.
REQ-036 Data load: flash model returns bytes 0x41+n -> after o_done, i_charAddress=0 gives 0x41 and i_charAddress=63 gives 0x80 (0x20 if FLASH_PAGE_READER_PRINTABLE_EN is defined).
REQ-037 Busy ignore: second i_start with i_address=0xABCDEF mid-DATA -> one transaction only; buffer matches the first address.
REQ-038 Reset abort: i_rst during byte 10 -> o_flashCS=1 next cycle, no o_done, all entries read 0x20.
REQ-039 Back-to-back: i_start the cycle o_done pulses is ignored; i_start once IDLE is re-entered is accepted; o_flashCS high for at least 2*CLK_DIV cycles between the two transactions.

Source files
------------

// File: rtl/flash_page_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flash_page_reader                                            |
// | Description : SPI mode-0 flash page loader (READ 0x03, 64 bytes) feeding   |
// |               a 64-entry text buffer with a registered read port.          |
// |               Optional macro FLASH_PAGE_READER_PRINTABLE_EN replaces       |
// |               non-printable received bytes with 0x20.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module flash_page_reader #(
    parameter int CLK_DIV        = 2,
    parameter int STARTUP_CYCLES = 2700
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [23:0] i_address,
    output logic        o_busy,
    output logic        o_done,
    input  logic        i_flashMISO,
    output logic        o_flashCLK,
    output logic        o_flashMOSI,
    output logic        o_flashCS,
    input  logic [5:0]  i_charAddress,
    output logic [7:0]  o_character
);

    localparam logic [7:0] c_cmd_read     = 8'h03;
    localparam logic [7:0] c_space        = 8'h20;
    localparam int         c_startup_w    = $clog2(STARTUP_CYCLES + 2);
    localparam logic [7:0] c_div_last     = 8'(CLK_DIV - 1);
    localparam logic [9:0] c_last_cmd_bit = 10'd31;
    localparam logic [9:0] c_last_bit     = 10'd543;

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CMD     = 3'd2,
        ST_DATA    = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    state_t                 r_state,       w_state_next;
    logic [c_startup_w-1:0] r_startup_cnt, w_startup_cnt_next;
    logic [7:0]             r_div,         w_div_next;
    logic                   r_phase,       w_phase_next;
    logic [9:0]             r_bit_cnt,     w_bit_cnt_next;
    logic [31:0]            r_shift,       w_shift_next;
    logic [6:0]             r_rx,          w_rx_next;
    logic                   r_busy,        w_busy_next;
    logic                   r_done,        w_done_next;
    logic                   r_sclk,        w_sclk_next;
    logic                   r_cs,          w_cs_next;

    logic                   w_half_end;
    logic [8:0]             w_data_idx;
    logic [7:0]             w_rx_byte;
    logic [7:0]             w_store_byte;
    logic                   w_wr_en;
    logic [5:0]             w_wr_idx;

    logic [7:0]             r_buf [64];
    logic [7:0]             r_char;

    assign w_half_end = (r_div == c_div_last);
    // Bit counter includes the 32 command bits; modulo-512 subtraction gives the data bit index.
    assign w_data_idx = r_bit_cnt[8:0] - 9'd32;
    assign w_rx_byte  = {r_rx, i_flashMISO};
    assign w_wr_idx   = w_data_idx[8:3];

`ifdef FLASH_PAGE_READER_PRINTABLE_EN
    assign w_store_byte = (w_rx_byte >= 8'h20 && w_rx_byte <= 8'h7E) ? w_rx_byte : c_space;
`else
    assign w_store_byte = w_rx_byte;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_STARTUP;
            r_startup_cnt <= '0;
            r_div         <= '0;
            r_phase       <= 1'b0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_rx          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_sclk        <= 1'b0;
            r_cs          <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_startup_cnt <= w_startup_cnt_next;
            r_div         <= w_div_next;
            r_phase       <= w_phase_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_shift       <= w_shift_next;
            r_rx          <= w_rx_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_sclk        <= w_sclk_next;
            r_cs          <= w_cs_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_startup_cnt_next = r_startup_cnt;
        w_div_next         = r_div;
        w_phase_next       = r_phase;
        w_bit_cnt_next     = r_bit_cnt;
        w_shift_next       = r_shift;
        w_rx_next          = r_rx;
        w_busy_next        = r_busy;
        w_done_next        = 1'b0;
        w_sclk_next        = r_sclk;
        w_cs_next          = r_cs;
        w_wr_en            = 1'b0;

        unique case (r_state)
            ST_STARTUP: begin
                if (int'(r_startup_cnt) + 1 >= STARTUP_CYCLES) begin
                    w_state_next       = ST_IDLE;
                    w_startup_cnt_next = '0;
                end else begin
                    w_startup_cnt_next = r_startup_cnt + c_startup_w'(1);
                end
            end
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next   = ST_CMD;
                    w_busy_next    = 1'b1;
                    w_cs_next      = 1'b0;
                    w_sclk_next    = 1'b0;
                    w_div_next     = '0;
                    w_phase_next   = 1'b0;
                    w_bit_cnt_next = '0;
                    w_rx_next      = '0;
                    w_shift_next   = {c_cmd_read, i_address};
                end
            end
            ST_CMD, ST_DATA: begin
                if (!w_half_end) begin
                    w_div_next = r_div + 8'd1;
                end else if (!r_phase) begin
                    // Rising edge: MISO is sampled on the same edge that raises SCLK.
                    w_div_next   = '0;
                    w_phase_next = 1'b1;
                    w_sclk_next  = 1'b1;
                    w_rx_next    = {r_rx[5:0], i_flashMISO};
                    w_wr_en      = (r_state == ST_DATA) && (w_data_idx[2:0] == 3'd7);
                end else begin
                    // Falling edge: MOSI advances to the next bit while SCLK is low.
                    w_div_next     = '0;
                    w_phase_next   = 1'b0;
                    w_sclk_next    = 1'b0;
                    w_shift_next   = {r_shift[30:0], 1'b0};
                    w_bit_cnt_next = r_bit_cnt + 10'd1;
                    if (r_state == ST_CMD && r_bit_cnt == c_last_cmd_bit) begin
                        w_state_next = ST_DATA;
                    end
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_next   = ST_FINISH;
                        w_cs_next      = 1'b1;
                        w_done_next    = 1'b1;
                        w_busy_next    = 1'b0;
                        w_bit_cnt_next = '0;
                    end
                end
            end
            ST_FINISH: begin
                // Two half-periods of chip-select high before the next command can start.
                if (!w_half_end) begin
                    w_div_next = r_div + 8'd1;
                end else begin
                    w_div_next   = '0;
                    w_phase_next = ~r_phase;
                    if (r_phase) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_STARTUP;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 64; i++) begin
                r_buf[i] <= c_space;
            end
            r_char <= c_space;
        end else begin
            if (w_wr_en) begin
                r_buf[w_wr_idx] <= w_store_byte;
            end
            r_char <= r_buf[i_charAddress];
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_flashCLK  = r_sclk;
    assign o_flashMOSI = r_shift[31];
    assign o_flashCS   = r_cs;
    assign o_character = r_char;

endmodule
`default_nettype wire

// File: tb/tb_flash_page_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_flash_page_reader                                         |
// | Description : Directed bench for flash_page_reader with an SPI flash model |
// |               returning byte n = address[7:0] - 4 + n.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_flash_page_reader;

    localparam int CLK_DIV        = 2;
    localparam int STARTUP_CYCLES = 10;
    localparam int XFER_CYCLES    = 1 + 1088 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] address;
    logic        busy;
    logic        done;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic        cs;
    logic [5:0]  char_addr;
    logic [7:0]  character;

    always #5 clk = ~clk;

    flash_page_reader #(
        .CLK_DIV        (CLK_DIV),
        .STARTUP_CYCLES (STARTUP_CYCLES)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_address     (address),
        .o_busy        (busy),
        .o_done        (done),
        .i_flashMISO   (miso),
        .o_flashCLK    (sclk),
        .o_flashMOSI   (mosi),
        .o_flashCS     (cs),
        .i_charAddress (char_addr),
        .o_character   (character)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc        = 0;
    logic        prev_sclk  = 1'b0;
    logic        prev_mosi  = 1'b0;
    logic        prev_cs    = 1'b1;
    int          last_rise  = -1;
    int          hi_len     = 0;
    int          bad_period = 0;
    int          bad_high   = 0;
    int          mosi_viol  = 0;
    int          cs_falls   = 0;
    int          cs_hi_run  = 0;
    int          last_gap   = 0;
    int          done_count = 0;
    int          fm_rises   = 0;
    logic [31:0] fm_cmd     = '0;
    logic [7:0]  fm_byte;
    int          fm_k;

    function automatic logic [7:0] filt(input logic [7:0] b);
`ifdef FLASH_PAGE_READER_PRINTABLE_EN
        return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h20;
`else
        return b;
`endif
    endfunction

    function automatic logic [7:0] model_byte(input logic [23:0] a, input int n);
        return a[7:0] - 8'h04 + 8'(n);
    endfunction

    // Flash model and SPI protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!cs && prev_cs) begin
            cs_falls++;
            last_gap  = cs_hi_run;
            fm_rises  = 0;
            fm_cmd    = '0;
            last_rise = -1;
        end
        cs_hi_run = cs ? cs_hi_run + 1 : 0;
        if (done) done_count++;
        if (sclk && (mosi != prev_mosi)) mosi_viol++;
        if (sclk && !prev_sclk) begin
            if (last_rise >= 0 && (cyc - last_rise) != 2 * CLK_DIV) bad_period++;
            last_rise = cyc;
            hi_len    = 0;
            if (fm_rises < 32) fm_cmd = {fm_cmd[30:0], mosi};
            fm_rises++;
        end
        if (sclk) hi_len++;
        if (!sclk && prev_sclk) begin
            if (hi_len != CLK_DIV) bad_high++;
            if (fm_rises >= 32 && fm_rises < 544) begin
                fm_k    = fm_rises - 32;
                fm_byte = model_byte(fm_cmd[23:0], fm_k / 8);
                miso    = fm_byte[7 - (fm_k % 8)];
            end
        end
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_cs   = cs;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 32'(n), 32'(XFER_CYCLES));
    endtask

    task automatic wait_rises(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (fm_rises >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("sclk_rise_timeout", 32'(fm_rises), 32'(target));
    endtask

    task automatic pulse_start(input logic [23:0] a);
        start   = 1'b1;
        address = a;
        tick();
        start   = 1'b0;
    endtask

    typedef struct {
        logic [5:0] idx;
        logic [7:0] raw;
        string      name;
    } rd_vec_t;

    rd_vec_t vec_a[6];
    rd_vec_t vec_b[5];

    initial begin
        int n;
        int dc;
        int cf;
        int bad;

        vec_a[0] = '{6'd0,  8'h41, "pageA_e0"};
        vec_a[1] = '{6'd1,  8'h42, "pageA_e1"};
        vec_a[2] = '{6'd10, 8'h4B, "pageA_e10"};
        vec_a[3] = '{6'd31, 8'h60, "pageA_e31"};
        vec_a[4] = '{6'd62, 8'h7F, "pageA_e62"};
        vec_a[5] = '{6'd63, 8'h80, "pageA_e63"};
        vec_b[0] = '{6'd0,  8'hFC, "pageB_e0"};
        vec_b[1] = '{6'd3,  8'hFF, "pageB_e3"};
        vec_b[2] = '{6'd4,  8'h00, "pageB_e4"};
        vec_b[3] = '{6'd35, 8'h1F, "pageB_e35"};
        vec_b[4] = '{6'd63, 8'h3B, "pageB_e63"};

        rst = 1'b1; start = 1'b0; address = '0; miso = 1'b0; char_addr = '0;
        tick();
        tick();
        check("rst_cs",   32'(cs),        32'd1);
        check("rst_sclk", 32'(sclk),      32'd0);
        check("rst_mosi", 32'(mosi),      32'd0);
        check("rst_busy", 32'(busy),      32'd0);
        check("rst_done", 32'(done),      32'd0);
        check("rst_char", 32'(character), 32'h20);
        rst = 1'b0;

        // Start during STARTUP is dropped; start after STARTUP is taken.
        repeat (4) tick();
        pulse_start(24'h012345);
        repeat (6) tick();
        check("startup_ignore_cs_falls", 32'(cs_falls), 32'd0);
        check("startup_ignore_busy",     32'(busy),     32'd0);
        pulse_start(24'h012345);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_cs",   32'(cs),   32'd0);
        check("accept_sclk", 32'(sclk), 32'd0);
        wait_done(n);
        check("done_latency",   32'(1 + n),      32'(XFER_CYCLES));
        check("busy_at_done",   32'(busy),       32'd0);
        check("cs_at_done",     32'(cs),         32'd1);
        check("cmd_bits",       fm_cmd,          32'h03012345);
        check("sclk_rises",     32'(fm_rises),   32'd544);
        tick();
        check("done_one_cycle", 32'(done),       32'd0);
        check("done_count_a",   32'(done_count), 32'd1);

        for (int i = 0; i < 6; i++) begin
            char_addr = vec_a[i].idx;
            tick();
            check(vec_a[i].name, 32'(character), 32'(filt(vec_a[i].raw)));
        end
        char_addr = 6'd0;
        tick();
        char_addr = 6'd63;
        #1;
        check("read_latency_hold", 32'(character), 32'(filt(8'h41)));
        tick();
        check("read_latency_new",  32'(character), 32'(filt(8'h80)));

        // Reset in the middle of byte 10 aborts the load and clears the buffer.
        pulse_start(24'h012345);
        wait_rises(32 + 84);
        for (int i = 0; i < 20 && sclk; i++) tick();
        dc  = done_count;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cs",   32'(cs),   32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sclk", 32'(sclk), 32'd0);
        repeat (30) tick();
        check("abort_no_done", 32'(done_count), 32'(dc));
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            char_addr = 6'(i);
            tick();
            if (character !== 8'h20) bad++;
        end
        check("abort_buffer_spaces", 32'(bad), 32'd0);

        // Back-to-back: start during FINISH dropped, start once IDLE taken.
        pulse_start(24'h012345);
        wait_done(n);
        pulse_start(24'hABCDEF);
        check("finish_start_ignored_busy", 32'(busy), 32'd0);
        check("finish_start_ignored_cs",   32'(cs),   32'd1);
        repeat (2 * CLK_DIV - 1) tick();
        cf = cs_falls;
        pulse_start(24'h000100);
        check("b2b_accept_busy", 32'(busy), 32'd1);
        tick();
        check("b2b_one_fall",  32'(cs_falls), 32'(cf + 1));
        check("cs_gap_min",    32'(last_gap >= 2 * CLK_DIV), 32'd1);

        // Mid-DATA: unwritten entries keep the previous page; a second start is ignored.
        wait_rises(32 + 100);
        char_addr = 6'd63;
        tick();
        check("live_read_old", 32'(character), 32'(filt(8'h80)));
        char_addr = 6'd0;
        tick();
        check("live_read_new", 32'(character), 32'(filt(8'hFC)));
        pulse_start(24'hABCDEF);
        check("busy_start_ignored", 32'(busy), 32'd1);
        wait_done(n);
        check("busy_ignore_falls", 32'(cs_falls), 32'(cf + 1));
        check("busy_ignore_cmd",   fm_cmd,        32'h03000100);
        for (int i = 0; i < 5; i++) begin
            char_addr = vec_b[i].idx;
            tick();
            check(vec_b[i].name, 32'(character), 32'(filt(vec_b[i].raw)));
        end
        repeat (10) tick();
        check("no_extra_xfer", 32'(cs_falls), 32'(cf + 1));

        check("sclk_period_errors", 32'(bad_period), 32'd0);
        check("sclk_high_errors",   32'(bad_high),   32'd0);
        check("mosi_change_high",   32'(mosi_viol),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
